// File: rtl/sched_pkg.sv
// Shared types and constants for the quantum scheduler.
package sched_pkg;

    localparam int NPROG_DEF           = 8;
    localparam int QW_DEF              = 16;
    localparam int DEFAULT_QUANTUM_DEF = 100;

    typedef enum logic [1:0] {
        OS_RUN   = 2'd0,
        USER_RUN = 2'd1,
        TRAP     = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_QUANTUM = 2'b01;
    localparam logic [1:0] CAUSE_HALT    = 2'b10;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search over user slots 1..NPROG-1. The scan starts just after
// last_id, wraps past NPROG-1 back to slot 1, and visits last_id itself last.
// Slot 0 (the OS) is never a candidate.
module rr_picker #(
    parameter int NPROG = 8,
    parameter int IDW   = $clog2(NPROG)
) (
    input  logic [NPROG-1:0] mask,
    input  logic [IDW-1:0]   last_id,
    output logic [IDW-1:0]   next_id,
    output logic             none
);

    // First set mask bit found walking upward from last_id with wrap
    always_comb begin
        int base;
        int idx;
        next_id = '0;
        none    = 1'b1;
        idx     = 0;
        // A last_id of 0 means no user program has run yet: start at slot 1.
        base    = (last_id == '0) ? (NPROG - 1) : int'(last_id);
        for (int k = 1; k < NPROG; k++) begin
            idx = base + k;
            if (idx > NPROG - 1) begin
                idx = idx - (NPROG - 1);
            end
            if (none && mask[idx[IDW-1:0]]) begin
                next_id = idx[IDW-1:0];
                none    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive quantum scheduler: the OS (slot 0) launches user programs, each
// running for a quantum of retired instructions before trapping back to the OS.
// Handshake: there is none; every decoded command is a single-cycle strobe that
// is acted on at the next rising clock edge only in the state that honours it.
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NPROG           = NPROG_DEF,
    parameter int QW              = QW_DEF,
    parameter int DEFAULT_QUANTUM = DEFAULT_QUANTUM_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     retire,
    input  logic                     nextProgram,
    input  logic                     endProgram,
    input  logic                     defquantum,
    input  logic                     changeProgram,
    input  logic [QW-1:0]            operand,
    output logic                     user_mode,
    output logic [$clog2(NPROG)-1:0] cur_id,
    output logic [$clog2(NPROG)-1:0] next_id,
    output logic                     next_none,
    output logic [NPROG-1:0]         active_mask,
    output logic [QW-1:0]            remaining,
    output logic                     trap,
    output logic [1:0]               trap_cause,
    output logic                     sys_halted,
    output state_t                   fsm_state
);

    localparam int IDW = $clog2(NPROG);

    state_t          state;
    logic [QW-1:0]   quantum;
    logic [IDW-1:0]  last_user_id;
    logic [IDW-1:0]  pick_id;
    logic            pick_none;
    logic [IDW-1:0]  target_id;
    logic            counting;
    logic            expire;

    assign target_id = operand[IDW-1:0];
    assign fsm_state = state;
    // A retire only counts while preemption is enabled and budget remains.
    assign counting  = retire && (quantum != '0) && (remaining != '0);
    assign expire    = counting && (remaining == QW'(1));

    rr_picker #(
        .NPROG (NPROG),
        .IDW   (IDW)
    ) u_picker (
        .mask    (active_mask),
        .last_id (last_user_id),
        .next_id (pick_id),
        .none    (pick_none)
    );

    // Scheduler FSM with all outputs registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= OS_RUN;
            quantum      <= QW'(DEFAULT_QUANTUM);
            remaining    <= '0;
            cur_id       <= '0;
            next_id      <= '0;
            last_user_id <= '0;
            next_none    <= 1'b0;
            active_mask  <= '0;
            trap         <= 1'b0;
            trap_cause   <= 2'b00;
            user_mode    <= 1'b0;
            sys_halted   <= 1'b0;
        end else begin
            case (state)
                OS_RUN: begin
                    trap      <= 1'b0;
                    user_mode <= 1'b0;
                    cur_id    <= '0;
                    if (endProgram) begin
                        state      <= HALTED;
                        sys_halted <= 1'b1;
                    end else begin
                        if (defquantum) begin
                            quantum <= operand;
                        end
                        if (nextProgram) begin
                            next_none <= pick_none;
                            if (!pick_none) begin
                                next_id <= pick_id;
                            end
                        end
                        // Slot 0 is the OS itself and cannot be launched.
                        if (changeProgram && (target_id != '0)) begin
                            active_mask[target_id] <= 1'b1;
                            cur_id                 <= target_id;
                            remaining              <= quantum;
                            user_mode              <= 1'b1;
                            state                  <= USER_RUN;
                        end
                    end
                end
                USER_RUN: begin
                    if (counting) begin
                        remaining <= remaining - QW'(1);
                    end
                    if (endProgram || expire) begin
                        state        <= TRAP;
                        trap         <= 1'b1;
                        user_mode    <= 1'b0;
                        cur_id       <= '0;
                        last_user_id <= cur_id;
                        // A halt outranks a simultaneous quantum expiry.
                        trap_cause   <= endProgram ? CAUSE_HALT : CAUSE_QUANTUM;
                        if (endProgram) begin
                            active_mask[cur_id] <= 1'b0;
                        end
                    end
                end
                TRAP: begin
                    trap  <= 1'b0;
                    state <= OS_RUN;
                end
                default: begin
                    sys_halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Bench for quantum_scheduler: directed scenarios followed by random command
// streams, every cycle compared against a behavioural model of the scheduler.
module tb_quantum_scheduler;
    import sched_pkg::*;

    localparam int NPROG = 8;
    localparam int QW    = 16;
    localparam int DQ    = 100;
    localparam int IDW   = $clog2(NPROG);

    localparam int M_OS   = 0;
    localparam int M_USER = 1;
    localparam int M_TRAP = 2;
    localparam int M_HALT = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             retire, nextProgram, endProgram, defquantum, changeProgram;
    logic [QW-1:0]    operand;
    logic             user_mode;
    logic [IDW-1:0]   cur_id, next_id;
    logic             next_none;
    logic [NPROG-1:0] active_mask;
    logic [QW-1:0]    remaining;
    logic             trap;
    logic [1:0]       trap_cause;
    logic             sys_halted;
    state_t           fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    int               m_mode, m_q, m_rem, m_cur, m_last, m_next;
    int               m_none, m_trap, m_cause, m_halt, m_user;
    logic [NPROG-1:0] m_mask;

    // clock / reset block
    always #5 clock = ~clock;

    quantum_scheduler #(
        .NPROG (NPROG), .QW (QW), .DEFAULT_QUANTUM (DQ)
    ) dut (
        .clock (clock), .reset (reset), .retire (retire),
        .nextProgram (nextProgram), .endProgram (endProgram),
        .defquantum (defquantum), .changeProgram (changeProgram),
        .operand (operand), .user_mode (user_mode), .cur_id (cur_id),
        .next_id (next_id), .next_none (next_none),
        .active_mask (active_mask), .remaining (remaining), .trap (trap),
        .trap_cause (trap_cause), .sys_halted (sys_halted),
        .fsm_state (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_OS; m_q = DQ; m_rem = 0; m_cur = 0; m_last = 0; m_next = 0;
        m_none = 0; m_trap = 0; m_cause = 0; m_halt = 0; m_user = 0; m_mask = '0;
    endtask

    // One clock edge of scheduler behaviour, from the current input values
    task automatic model_cycle();
        int tid, oldq, c;
        bit found, expired;
        tid = int'(operand) % NPROG;
        oldq = m_q;
        found = 0;
        expired = 0;
        case (m_mode)
            M_OS: begin
                m_trap = 0;
                if (endProgram) begin
                    m_mode = M_HALT;
                    m_halt = 1;
                end else begin
                    if (defquantum) m_q = int'(operand);
                    if (nextProgram) begin
                        for (int k = 1; k < NPROG; k++) begin
                            c = (m_last + k - 1) % (NPROG - 1) + 1;
                            if (!found && m_mask[c]) begin
                                m_next = c;
                                found = 1;
                            end
                        end
                        m_none = found ? 0 : 1;
                    end
                    if (changeProgram && tid != 0) begin
                        m_mask[tid] = 1'b1;
                        m_cur = tid;
                        m_rem = oldq;
                        m_user = 1;
                        m_mode = M_USER;
                    end
                end
            end
            M_USER: begin
                if (retire && m_q != 0 && m_rem > 0) begin
                    m_rem--;
                    expired = (m_rem == 0);
                end
                if (endProgram || expired) begin
                    m_mode = M_TRAP;
                    m_trap = 1;
                    m_cause = endProgram ? 2 : 1;
                    if (endProgram) m_mask[m_cur] = 1'b0;
                    m_last = m_cur;
                    m_cur = 0;
                    m_user = 0;
                end
            end
            M_TRAP: begin
                m_trap = 0;
                m_mode = M_OS;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".user_mode"}, user_mode, m_user);
        check({tag, ".cur_id"}, cur_id, m_cur);
        check({tag, ".next_id"}, next_id, m_next);
        check({tag, ".next_none"}, next_none, m_none);
        check({tag, ".mask"}, active_mask, m_mask);
        check({tag, ".remaining"}, remaining, m_rem);
        check({tag, ".trap"}, trap, m_trap);
        check({tag, ".cause"}, trap_cause, m_cause);
        check({tag, ".halted"}, sys_halted, m_halt);
    endtask

    // driver: apply one cycle of inputs, then compare just after the edge
    task automatic step(input bit r, input bit np, input bit ep, input bit dq,
                        input bit cp, input logic [QW-1:0] op);
        retire = r; nextProgram = np; endProgram = ep;
        defquantum = dq; changeProgram = cp; operand = op;
        @(posedge clock);
        model_cycle();
        #1;
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    // asynchronous reset asserted between edges; outputs checked before the next edge
    task automatic do_reset();
        retire = 0; nextProgram = 0; endProgram = 0;
        defquantum = 0; changeProgram = 0; operand = '0;
        reset = 1'b1;
        #2;
        model_reset();
        compare_all("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cmd;
        do_reset();
        check("reset.mask", active_mask, 0);
        check("reset.remaining", remaining, 0);

        // quantum 3 on slot 2, fourth retire lands in TRAP and is not counted
        step(0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 0, 1, 2);
        check("q3.user_mode", user_mode, 1);
        check("q3.cur_id", cur_id, 2);
        check("q3.rem0", remaining, 3);
        step(1, 0, 0, 0, 0, 0);
        check("q3.rem1", remaining, 2);
        step(1, 0, 0, 0, 0, 0);
        check("q3.rem2", remaining, 1);
        step(1, 0, 0, 0, 0, 0);
        check("q3.trap", trap, 1);
        check("q3.cause", trap_cause, 2'b01);
        step(1, 0, 0, 0, 0, 0);
        check("q3.trap_gone", trap, 0);
        check("q3.mask", active_mask, 8'b0000_0100);

        // slots 2 and 5 live, last user 5 -> pick wraps to 2
        step(0, 0, 0, 0, 1, 5);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0);
        check("rr.next_id", next_id, 2);
        check("rr.next_none", next_none, 0);
        step(0, 0, 0, 0, 1, 2); step(0, 0, 1, 0, 0, 0); idle(1);
        step(0, 0, 0, 0, 1, 5); step(0, 0, 1, 0, 0, 0); idle(1);
        step(0, 1, 0, 0, 0, 0);
        check("rr.empty_none", next_none, 1);
        check("rr.empty_keep", next_id, 2);

        // halt coinciding with expiring retire on slot 3
        step(0, 0, 0, 0, 1, 3);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        check("coin.trap", trap, 1);
        check("coin.cause", trap_cause, 2'b10);
        check("coin.mask3", active_mask[3], 0);
        idle(1);

        // quantum 0: no preemption
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 1000; i++) step(1, 0, 0, 0, 0, 0);
        check("q0.remaining", remaining, 0);
        check("q0.user_mode", user_mode, 1);

        // privileged commands ignored in user mode
        step(0, 0, 0, 1, 0, 7);
        step(0, 0, 0, 0, 1, 4);
        check("priv.cur_id", cur_id, 1);
        step(0, 0, 1, 0, 0, 0); idle(1);
        step(0, 0, 0, 0, 1, 4);
        check("priv.quantum_kept", remaining, 0);
        check("priv.cur_id4", cur_id, 4);
        step(0, 0, 1, 0, 0, 0); idle(1);

        // reset mid-quantum, then OS halt is sticky
        step(0, 0, 0, 1, 0, 50);
        step(0, 0, 0, 0, 1, 6);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        do_reset();
        check("midrst.mask", active_mask, 0);
        check("midrst.user", user_mode, 0);
        step(0, 0, 1, 0, 0, 0);
        check("halt.sys", sys_halted, 1);
        step(0, 0, 0, 0, 1, 3);
        step(1, 1, 1, 1, 0, 9);
        check("halt.sticky", sys_halted, 1);
        check("halt.user", user_mode, 0);

        // random command streams
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0 || (m_mode == M_HALT && $urandom_range(0, 19) == 0)) begin
                do_reset();
            end else begin
                cmd = $urandom_range(0, 99);
                if (cmd < 3)       step($urandom_range(0, 1), 0, 1, 0, 0, '0);
                else if (cmd < 25) step($urandom_range(0, 1), 0, 0, 1, 0, QW'($urandom_range(0, 6)));
                else if (cmd < 50) step($urandom_range(0, 1), 0, 0, 0, 1, QW'($urandom));
                else if (cmd < 70) step($urandom_range(0, 1), 1, 0, 0, 0, QW'($urandom));
                else               step($urandom_range(0, 1), 0, 0, 0, 0, QW'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/quantum_scheduler.md
QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

Interface
REQ-001 Parameters: NPROG, default 8, number of program slots; slot 0 is the OS.
REQ-002 Parameters: QW, default 16, quantum counter width.
REQ-003 Parameters: DEFAULT_QUANTUM, default 100, quantum loaded at reset.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Ports:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- retire  in  1  one instruction completes this cycle (stop not asserted)
- nextProgram  in  1  decoded nextprogram
- endProgram  in  1  decoded halt
- defquantum  in  1  decoded quantum
- changeProgram  in  1  decoded changeprogram
- operand  in  QW  register operand: quantum value for defquantum; low log2(NPROG) bits are target id for changeProgram
- user_mode  out  1  user program running
- cur_id  out  log2(NPROG)  running slot
- next_id  out  log2(NPROG)  round-robin pick from nextProgram
- next_none  out  1  last pick found no active user slot
- active_mask  out  NPROG  live user slots; bit 0 always 0
- remaining  out  QW  instructions left in the current quantum
- trap  out  1  one-cycle pulse: control returns to OS
- trap_cause  out  2  01 quantum expired, 10 program halted; valid with trap
- sys_halted  out  1  sticky; OS executed halt

Function
REQ-006 The block SHALL implement states OS_RUN, USER_RUN, TRAP, HALTED.
REQ-007 OS_RUN SHALL hold user_mode=0 and cur_id=0.
REQ-008 In OS_RUN, defquantum SHALL load quantum := operand at the next edge.
REQ-009 In OS_RUN, changeProgram with target id≠0 SHALL do all of the following at the next edge: set active_mask[id], set cur_id:=id, set remaining:=quantum, enter USER_RUN.
REQ-010 In OS_RUN, changeProgram with target id=0 SHALL be ignored.
REQ-011 In OS_RUN, nextProgram SHALL register next_id := first set active_mask bit strictly after last_user_id, scanning upward, wrapping over 1..NPROG-1, and including last_user_id itself last.
REQ-012 nextProgram with an empty mask SHALL set next_none=1 and leave next_id unchanged.
REQ-013 In OS_RUN, endProgram SHALL enter HALTED.
REQ-014 In USER_RUN, defquantum, changeProgram and nextProgram SHALL be ignored (privileged).
REQ-015 In USER_RUN with quantum≠0, each retire SHALL decrement remaining.
REQ-016 A retire when remaining=1 SHALL enter TRAP with cause 01.
REQ-017 Quantum=0 SHALL disable preemption; remaining SHALL hold 0.
REQ-018 In USER_RUN, endProgram SHALL clear active_mask[cur_id] and enter TRAP with cause 10.
REQ-019 When endProgram and an expiring retire coincide, cause 10 SHALL win and the mask bit SHALL be cleared.
REQ-020 TRAP SHALL last exactly one cycle with trap=1, user_mode=0, cur_id=0, last_user_id:=preempted id; the next state SHALL be OS_RUN.
REQ-021 All inputs SHALL be ignored in TRAP.
REQ-022 HALTED SHALL set sys_halted=1 and ignore all inputs until reset.
REQ-023 trap SHALL be asserted on the cycle after the expiring retire or the endProgram.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 Reset SHALL asynchronously force: state OS_RUN, quantum=DEFAULT_QUANTUM, remaining=0, cur_id=0, next_id=0, last_user_id=0, next_none=0, active_mask=0, trap=0, trap_cause=00, user_mode=0, sys_halted=0.
REQ-026 Reset asserted mid-quantum SHALL discard all slot state.

Structure
REQ-027 Package sched_pkg SHALL hold the state enum, the trap-cause constants (CAUSE_QUANTUM=2'b01, CAUSE_HALT=2'b10) and the NPROG/QW defaults.
REQ-028 The round-robin search SHALL be a combinational sub-module rr_picker (mask, last id -> next id, none).

Verification
REQ-029 Reset, defquantum operand=3, changeProgram operand=2, four retires -> user_mode=1, cur_id=2, remaining 3,2,1, trap=1 with cause 01 on the cycle after the third retire, the fourth retire is not counted, mask=0000_0100.
REQ-030 Slots 2 and 5 active, last_user_id=5, nextProgram -> next_id=2; then mask=0 and nextProgram -> next_none=1.
REQ-031 In USER_RUN id=3 with remaining=1, endProgram coincides with retire -> trap_cause=10 and active_mask[3]=0.
REQ-032 Quantum=0, changeProgram id=1, 1000 retires -> no trap, remaining stays 0.
REQ-033 In USER_RUN, defquantum operand=7 and changeProgram id=4 -> quantum and cur_id unchanged.
REQ-034 Reset pulse mid-quantum -> all outputs at reset values within the same cycle; OS endProgram -> sys_halted=1 and stays 1.
